// File: rtl/pipeline_flow_ctrl.sv
// rtl/pipeline_flow_ctrl.sv - RV32I pipeline flow controller: reset warm-up, then
// trap/redirect/load-use/memory-stall arbitration driving flush, stall and PC select.
module pipeline_flow_ctrl #(
  parameter int FLUSH_STAGES     = 2,
  parameter int RESET_HOLD       = 2,
  parameter int REDIRECT_FLUSH   = 2,
  parameter int REDIRECT_BUBBLES = 0,
  parameter int LU_BUBBLE_STAGE  = 1,
  parameter int STALL_TIMEOUT    = 256
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    trap_in,
  input  logic                    branch_taken_in,
  input  logic                    jump_in,
  input  logic                    load_use_in,
  input  logic                    ext_stall_in,
  output logic [FLUSH_STAGES-1:0] flush_out,
  output logic                    stall_out,
  output logic                    pc_en_out,
  output logic [1:0]              pc_src_out,
  output logic [1:0]              state_out,
  output logic                    timeout_out
);

  typedef enum logic [1:0] {
    ST_RESET    = 2'b00,
    ST_WARMUP   = 2'b01,
    ST_RUN      = 2'b10,
    ST_REDIRECT = 2'b11
  } state_e;

  localparam logic [1:0] PC_RESET_VEC = 2'b00;
  localparam logic [1:0] PC_TARGET    = 2'b01;
  localparam logic [1:0] PC_TRAP_VEC  = 2'b10;
  localparam logic [1:0] PC_PLUS4     = 2'b11;

  localparam int HOLD_W  = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam int BUB_W   = (REDIRECT_BUBBLES > 0) ? $clog2(REDIRECT_BUBBLES + 1) : 1;
  localparam int STALL_W = $clog2(STALL_TIMEOUT + 1);

  localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [BUB_W-1:0]   BUB_INIT  = BUB_W'(REDIRECT_BUBBLES);
  localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_TIMEOUT);

  localparam logic [FLUSH_STAGES-1:0] FLUSH_ALL   = {FLUSH_STAGES{1'b1}};
  localparam logic [FLUSH_STAGES-1:0] FLUSH_REDIR =
    {FLUSH_STAGES{1'b1}} >> (FLUSH_STAGES - REDIRECT_FLUSH);
  localparam logic [FLUSH_STAGES-1:0] FLUSH_LU  = FLUSH_STAGES'(1) << LU_BUBBLE_STAGE;
  localparam logic [FLUSH_STAGES-1:0] FLUSH_BUB = FLUSH_STAGES'(1);

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [BUB_W-1:0]    bub_cnt_q, bub_cnt_d;
  logic [STALL_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic                timeout_q, timeout_d;

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    bub_cnt_d   = bub_cnt_q;
    stall_cnt_d = '0;
    timeout_d   = timeout_q | (stall_cnt_q == STALL_MAX);
    flush_out   = '0;
    stall_out   = 1'b0;
    pc_en_out   = 1'b1;
    pc_src_out  = PC_PLUS4;

    case (state_q)
      ST_RESET: begin
        flush_out  = FLUSH_ALL;
        pc_src_out = PC_RESET_VEC;
        if (RESET_HOLD > 0) begin
          state_d    = ST_WARMUP;
          hold_cnt_d = HOLD_INIT;
        end else begin
          state_d = ST_RUN;
        end
      end

      ST_WARMUP: begin
        flush_out  = FLUSH_ALL;
        pc_src_out = PC_RESET_VEC;
        hold_cnt_d = hold_cnt_q - HOLD_W'(1);
        if (hold_cnt_q <= HOLD_W'(1)) begin
          state_d    = ST_RUN;
          hold_cnt_d = '0;
        end
      end

      default: begin
        // Memory stall freezes everything, so pending requests stay with upstream.
        if (ext_stall_in) begin
          stall_out   = 1'b1;
          pc_en_out   = 1'b0;
          stall_cnt_d = (stall_cnt_q == STALL_MAX) ? stall_cnt_q
                                                   : stall_cnt_q + STALL_W'(1);
        end else if (trap_in) begin
          pc_src_out = PC_TRAP_VEC;
          flush_out  = FLUSH_ALL;
          state_d    = ST_RUN;
          bub_cnt_d  = '0;
        end else if (branch_taken_in || jump_in) begin
          pc_src_out = PC_TARGET;
          flush_out  = FLUSH_REDIR;
          if (REDIRECT_BUBBLES > 0) begin
            state_d   = ST_REDIRECT;
            bub_cnt_d = BUB_INIT;
          end else begin
            state_d   = ST_RUN;
            bub_cnt_d = '0;
          end
        end else if (load_use_in) begin
          stall_out = 1'b1;
          pc_en_out = 1'b0;
          flush_out = FLUSH_LU;
        end else if (state_q == ST_REDIRECT) begin
          flush_out = FLUSH_BUB;
          bub_cnt_d = bub_cnt_q - BUB_W'(1);
          if (bub_cnt_q <= BUB_W'(1)) begin
            state_d   = ST_RUN;
            bub_cnt_d = '0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= ST_RESET;
      hold_cnt_q  <= '0;
      bub_cnt_q   <= '0;
      stall_cnt_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      bub_cnt_q   <= bub_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      timeout_q   <= timeout_d;
    end
  end

  assign state_out   = state_q;
  assign timeout_out = timeout_q;

endmodule
